// File: rtl/uart_tx_queue.sv
// uart_tx_queue
// Byte FIFO in front of a UART sender.  Bytes written from the bus side are
// queued and handed to the sender one at a time.  Each hand-off is a
// one-cycle tx_en pulse.  The next byte is only offered after the sender
// has gone busy and then returned to free (tx_status 1->0->1).
//
// Ports
//   sysclk    : system clock, all state updates on the rising edge
//   reset     : synchronous, active-low reset
//   wr_en     : write strobe, one byte per asserted cycle
//   wr_data   : byte to enqueue
//   clr_ovf   : clears the sticky overflow flag
//   tx_status : sender status, 1 = free, 0 = transmitting
//   tx_data   : byte presented to the sender, held for the whole hand-off
//   tx_en     : one-cycle load pulse to the sender
//   full      : FIFO holds DEPTH bytes
//   empty     : FIFO holds no bytes
//   count     : number of bytes queued, 0..DEPTH
//   overflow  : sticky, set when a write was dropped because the FIFO was full
//   busy      : FIFO non-empty or a hand-off still in progress
module uart_tx_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    input  logic          tx_status,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_ok;
    logic          pop;

    // full is taken from the registered count, so a write in the same cycle
    // as a pop is still dropped when the FIFO was full at the edge.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign busy  = !empty || (state != IDLE);

    // Storage carries no reset; the write is suppressed during reset so a
    // strobe in the reset cycle leaves no trace.
    always_ff @(posedge sysclk) begin
        if (reset && wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers and count.  Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a dropped write beats a simultaneous clear.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // tx_data is only loaded on the IDLE->LOAD edge and is otherwise held.
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            tx_data <= 8'h00;
        end else if (pop) begin
            tx_data <= mem[rptr];
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hand-off sequencing.  WAIT_BUSY and WAIT_DONE together require a full
    // 1->0->1 cycle on tx_status before another byte may be popped.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && tx_status) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                tx_en     = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_status) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_status) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the FIFO entry count; it is a power of two, 2..64.
REQ-002 The block SHALL have parameter AW, default 3, giving the pointer width; AW equals log2(DEPTH).
REQ-003 The block SHALL have port sysclk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on rising sysclk.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write strobe from the bus side, one byte per asserted cycle.
REQ-006 The block SHALL have port wr_data, input, 8 bits: the byte to enqueue when wr_en=1.
REQ-007 The block SHALL have port clr_ovf, input, 1 bit: clears the overflow flag.
REQ-008 The block SHALL have port tx_status, input, 1 bit, driven by the sender: 1 means the sender is free, 0 means it is transmitting.
REQ-009 The block SHALL have port tx_data, output, 8 bits: the byte presented to the sender.
REQ-010 The block SHALL have port tx_en, output, 1 bit: a one-cycle load pulse to the sender.
REQ-011 The block SHALL have ports full and empty, output, 1 bit each: the FIFO status flags.
REQ-012 The block SHALL have port count, output, AW+1 bits: the number of bytes queued, 0..DEPTH.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write was dropped.
REQ-014 The block SHALL have port busy, output, 1 bit: 1 while FIFO is non-empty or the FSM is not IDLE.

Function
REQ-015 The FIFO SHALL be DEPTH x 8 with read/write pointers of AW bits that wrap modulo DEPTH; full=(count==DEPTH), empty=(count==0).
REQ-016 A write SHALL be accepted when wr_en=1 and full=0 at the sampling edge; the byte is stored at wptr, wptr increments, and count increments.
REQ-017 When wr_en=1 and full=1, the byte SHALL be dropped, all FIFO state SHALL stay unchanged, and overflow SHALL be set to 1 on that edge.
REQ-018 full SHALL be evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs in that cycle.
REQ-019 An accepted write and a pop in the same cycle SHALL leave count unchanged, with both pointers advancing.
REQ-020 Once set, overflow SHALL be cleared only by clr_ovf=1 or by reset; when clr_ovf=1 and a dropped write occur in the same cycle, the set SHALL win.
REQ-021 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-022 In IDLE, when empty=0 and tx_status=1, the FSM SHALL pop the head into the tx_data register, advance rptr, decrement count, and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-023 In LOAD, tx_en SHALL be 1 for exactly this one cycle, and the FSM SHALL go to WAIT_BUSY unconditionally.
REQ-024 In WAIT_BUSY, the FSM SHALL go to WAIT_DONE when tx_status=0 and stay otherwise, with no timeout.
REQ-025 In WAIT_DONE, the FSM SHALL go to IDLE when tx_status=1 and stay otherwise.
REQ-026 tx_en SHALL be 0 in every state except LOAD and SHALL be decoded glitch-free from the state register.
REQ-027 tx_data SHALL change only on the IDLE-to-LOAD edge and SHALL hold stable through LOAD, WAIT_BUSY and WAIT_DONE.
REQ-028 Latency: for a write sampled at edge E0 into an empty FIFO with the FSM in IDLE and tx_status=1, tx_en SHALL be high in the cycle between edges E1 and E2.
REQ-029 Back-to-back bytes SHALL be spaced by at least one IDLE cycle after tx_status returns to 1; the FSM SHALL never issue a second tx_en before observing tx_status 1->0->1.
REQ-030 If tx_status=0 while in IDLE, the FSM SHALL not pop and SHALL wait, so a byte is never lost to a busy sender.
REQ-031 Bytes SHALL leave in strict write order with no duplication.

Reset
REQ-032 While reset=0 at a rising edge, the block SHALL set wptr=0, rptr=0, count=0, state=IDLE, tx_data=8'h00, tx_en=0, overflow=0, empty=1, full=0 and busy=0.
REQ-033 Reset mid-transfer SHALL discard queued bytes and the in-flight handshake, and SHALL ignore wr_en in the reset cycle.
REQ-034 FIFO storage contents SHALL need no reset.

Verification
REQ-035 Single byte: write 8'hA5 at edge E0 with tx_status=1 -> tx_en=1 for one cycle after E1 with tx_data=8'hA5; model sender drops tx_status 3 cycles later and raises it 20 cycles after that -> FSM reaches IDLE and busy=0.
REQ-036 Fill and overflow: hold tx_status=0 and write 9 bytes 8'h01..8'h09 -> count=8, full=1, overflow=1, 8'h09 lost; release tx_status -> 8'h01..8'h08 are sent in order.
REQ-037 Wrap-around: 20 writes of 8'h10..8'h23 are interleaved with a model sender -> all 20 bytes are received in order, pointers wrap twice, and overflow=0.
REQ-038 Simultaneous events: a write in the same cycle as an IDLE pop with count=3 -> count stays 3; a write while full in the pop cycle -> dropped and overflow=1; clr_ovf together with a dropped write -> overflow=1.
REQ-039 Reset mid-operation: assert reset in WAIT_BUSY with count=5 -> next cycle state=IDLE, count=0, tx_en=0 and tx_data=8'h00, and no further tx_en occurs.
REQ-040 Stalled sender: tx_status stays 1 after tx_en -> FSM stays in WAIT_BUSY indefinitely and no second tx_en is issued.
